// File: rtl/sort_unit.sv
// Per-group thermometer sorter using an odd-even transposition network, one pass per cycle.
// Optional macro SORT_DESCENDING_EN packs ones toward the MSB end instead of the LSB end.
module sort_unit #(
    parameter int SAMPLES = 1,
    parameter int OSF     = 4
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   P,
    input  logic [SAMPLES*OSF-1:0] DataIn,
    output logic [SAMPLES*OSF-1:0] DataOut,
    output logic                   Valid
);

    localparam int W  = SAMPLES * OSF;
    localparam int CW = $clog2(OSF);

    typedef enum logic {
        S_IDLE,
        S_SORT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_p_d;
    logic [W-1:0]    r_work;
    logic [W-1:0]    w_pass;
    logic [CW-1:0]   r_cnt;
    logic            w_start;
    logic            w_last;

    assign w_start = P & ~r_p_d;
    assign w_last  = (r_cnt == CW'(OSF - 1));

    // Pairs in one pass are disjoint, so every exchange reads the old word.
    always_comb begin
        w_pass = r_work;
        for (int g = 0; g < SAMPLES; g++) begin
            for (int j = 0; j < OSF - 1; j++) begin
                if (j[0] == r_cnt[0]) begin
`ifdef SORT_DESCENDING_EN
                    w_pass[g*OSF+j]   = r_work[g*OSF+j] & r_work[g*OSF+j+1];
                    w_pass[g*OSF+j+1] = r_work[g*OSF+j] | r_work[g*OSF+j+1];
`else
                    w_pass[g*OSF+j]   = r_work[g*OSF+j] | r_work[g*OSF+j+1];
                    w_pass[g*OSF+j+1] = r_work[g*OSF+j] & r_work[g*OSF+j+1];
`endif
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_SORT;
            S_SORT: if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_p_d   <= 1'b0;
            r_work  <= '0;
            r_cnt   <= '0;
            DataOut <= '0;
            Valid   <= 1'b0;
        end else begin
            r_p_d <= P;
            Valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_work <= DataIn;
                    r_cnt  <= '0;
                end
            end else begin
                r_work <= w_pass;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    DataOut <= w_pass;
                    Valid   <= 1'b1;
                    r_cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_unit.sv
// Directed scoreboard bench for sort_unit: one 1x4 instance and one 2x4 instance.
// Expected words come from a popcount-based thermometer model.
module tb_sort_unit;

    localparam int OSF = 4;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       P1 = 1'b0;
    logic       P2 = 1'b0;
    logic [3:0] DataIn1 = '0;
    logic [7:0] DataIn2 = '0;
    logic [3:0] DataOut1;
    logic [7:0] DataOut2;
    logic       Valid1;
    logic       Valid2;

    int vectors = 0;
    int errs    = 0;
    int v1      = 0;
    int v2      = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Valid1) v1++;
        if (Valid2) v2++;
    end

    sort_unit #(.SAMPLES(1), .OSF(OSF)) u_dut1 (
        .CLK(CLK), .RST_n(RST_n), .P(P1),
        .DataIn(DataIn1), .DataOut(DataOut1), .Valid(Valid1)
    );

    sort_unit #(.SAMPLES(2), .OSF(OSF)) u_dut2 (
        .CLK(CLK), .RST_n(RST_n), .P(P2),
        .DataIn(DataIn2), .DataOut(DataOut2), .Valid(Valid2)
    );

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input int samples);
        logic [31:0] r;
        int n;
        r = '0;
        for (int g = 0; g < samples; g++) begin
            n = 0;
            for (int j = 0; j < OSF; j++) n += int'(d[g*OSF+j]);
            for (int j = 0; j < OSF; j++) begin
`ifdef SORT_DESCENDING_EN
                r[g*OSF+j] = (j >= OSF - n);
`else
                r[g*OSF+j] = (j < n);
`endif
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called just after the start edge; expects Valid exactly OSF edges later.
    task automatic wait1(input string tag);
        int cyc;
        logic [31:0] e;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!Valid1 && cyc < OSF + 4);
        chk({tag, "_lat"}, 32'(cyc), 32'(OSF));
        e = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD;
        chk({tag, "_data"}, 32'(DataOut1), e);
        tick();
        chk({tag, "_vdrop"}, 32'(Valid1), 32'd0);
    endtask

    task automatic run1(input logic [3:0] d, input string tag);
        tick();
        P1 = 1'b1;
        DataIn1 = d;
        q1.push_back(model(32'(d), 1));
        tick();
        P1 = 1'b0;
        DataIn1 = ~d;
        wait1(tag);
    endtask

    initial begin
        int base;
        repeat (2) tick();
        chk("rst_dout1", 32'(DataOut1), 32'd0);
        chk("rst_valid1", 32'(Valid1), 32'd0);
        chk("rst_dout2", 32'(DataOut2), 32'd0);
        chk("rst_valid2", 32'(Valid2), 32'd0);
        RST_n = 1'b1;
        tick();

        run1(4'd12, "d12");
        run1(4'd1, "d1");
        run1(4'd2, "d2");
        run1(4'd4, "d4");
        run1(4'd14, "d14");
        run1(4'd0, "d0");
        run1(4'd15, "d15");
        run1(4'd5, "d5");

        // P held high for 20 cycles, DataIn changed mid-sort.
        base = v1;
        P1 = 1'b1;
        DataIn1 = 4'd12;
        q1.push_back(model(32'd12, 1));
        repeat (2) tick();
        DataIn1 = 4'd3;
        repeat (18) tick();
        P1 = 1'b0;
        repeat (3) tick();
        chk("held_pulses", 32'(v1 - base), 32'd1);
        chk("held_data", 32'(DataOut1), q1.pop_front());

        // Fresh start while busy must be ignored.
        base = v1;
        P1 = 1'b1;
        DataIn1 = 4'd14;
        q1.push_back(model(32'd14, 1));
        tick();
        P1 = 1'b0;
        tick();
        P1 = 1'b1;
        DataIn1 = 4'd1;
        tick();
        P1 = 1'b0;
        repeat (8) tick();
        chk("busy_pulses", 32'(v1 - base), 32'd1);
        chk("busy_data", 32'(DataOut1), q1.pop_front());

        // Start arriving on the completion edge must be ignored.
        base = v1;
        P1 = 1'b1;
        DataIn1 = 4'd13;
        q1.push_back(model(32'd13, 1));
        tick();
        P1 = 1'b0;
        DataIn1 = 4'd8;
        repeat (OSF - 1) tick();
        P1 = 1'b1;
        repeat (10) tick();
        P1 = 1'b0;
        tick();
        chk("edge_pulses", 32'(v1 - base), 32'd1);
        chk("edge_data", 32'(DataOut1), q1.pop_front());

        // Two groups in parallel.
        base = v2;
        P2 = 1'b1;
        DataIn2 = 8'hC1;
        q2.push_back(model(32'hC1, 2));
        tick();
        P2 = 1'b0;
        DataIn2 = 8'h00;
        repeat (OSF + 2) tick();
        chk("g2_pulses", 32'(v2 - base), 32'd1);
        chk("g2_data", 32'(DataOut2), q2.pop_front());

        // Reset two cycles into a sort aborts it.
        P2 = 1'b1;
        DataIn2 = 8'h7E;
        tick();
        P2 = 1'b0;
        repeat (2) tick();
        RST_n = 1'b0;
        #1;
        chk("abort_dout", 32'(DataOut2), 32'd0);
        chk("abort_valid", 32'(Valid2), 32'd0);
        base = v2;
        repeat (2) tick();
        RST_n = 1'b1;
        repeat (8) tick();
        chk("abort_pulses", 32'(v2 - base), 32'd0);
        chk("abort_hold", 32'(DataOut2), 32'd0);

        // P already high at reset release counts as a start.
        RST_n = 1'b0;
        P1 = 1'b1;
        DataIn1 = 4'd14;
        q1.push_back(model(32'd14, 1));
        tick();
        chk("rst2_dout1", 32'(DataOut1), 32'd0);
        RST_n = 1'b1;
        tick();
        P1 = 1'b0;
        DataIn1 = 4'd0;
        wait1("relstart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
